// File: rtl/decode_stage_pipe.sv
// Registered RV32/RV64 decode stage: decodes one instruction per cycle into execute
// operands and write controls, with load-use stall, flush and illegal-encoding detection.
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1,
  parameter int ZICSR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  output logic [4:0]      reg1_addr_o,
  output logic [4:0]      reg2_addr_o,
  input  logic [XLEN-1:0] reg1_data_i,
  input  logic [XLEN-1:0] reg2_data_i,
  input  logic [XLEN-1:0] csr_data_i,
  output logic [11:0]     csr_rd_addr_o,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [XLEN-1:0] op1_jump_o,
  output logic [XLEN-1:0] op2_jump_o,
  output logic [XLEN-1:0] reg1_data_o,
  output logic [XLEN-1:0] reg2_data_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_wr_addr_o,
  output logic            illegal_o,
  output logic            is_load_o,
  output logic            load_use_stall_o
);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] FOUR_X = {{(XLEN-3){1'b0}}, 3'd4};

  logic [6:0]      opcode_s;
  logic [4:0]      rd_s;
  logic [2:0]      f3_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [6:0]      f7_s;
  logic [XLEN-1:0] i_imm_s, s_imm_s, b_imm_s, u_imm_s, j_imm_s, uimm_s;

  assign opcode_s = inst_i[6:0];
  assign rd_s     = inst_i[11:7];
  assign f3_s     = inst_i[14:12];
  assign rs1_s    = inst_i[19:15];
  assign rs2_s    = inst_i[24:20];
  assign f7_s     = inst_i[31:25];

  assign i_imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign s_imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign b_imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign u_imm_s = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'h000};
  assign j_imm_s = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign uimm_s  = {{(XLEN-5){1'b0}}, inst_i[19:15]};

  logic            ill_s, rs1_used_s, rs2_used_s, rd_wr_s, csr_op_s, csr_wr_s, is_load_s;
  logic [XLEN-1:0] op1_s, op2_s, j1_s, j2_s;

  // Raw decode: classify the opcode, pick operands and flag reserved encodings.
  always_comb begin
    ill_s      = 1'b0;
    rs1_used_s = 1'b0;
    rs2_used_s = 1'b0;
    rd_wr_s    = 1'b0;
    csr_op_s   = 1'b0;
    csr_wr_s   = 1'b0;
    is_load_s  = 1'b0;
    op1_s      = ZERO_X;
    op2_s      = ZERO_X;
    j1_s       = ZERO_X;
    j2_s       = ZERO_X;
    case (opcode_s)
      OPC_LUI: begin
        rd_wr_s = 1'b1;
        op1_s   = u_imm_s;
      end
      OPC_AUIPC: begin
        rd_wr_s = 1'b1;
        op1_s   = u_imm_s;
        op2_s   = inst_addr_i;
      end
      OPC_JAL: begin
        rd_wr_s = 1'b1;
        op1_s   = inst_addr_i;
        op2_s   = FOUR_X;
        j1_s    = inst_addr_i;
        j2_s    = j_imm_s;
      end
      OPC_JALR: begin
        rd_wr_s    = 1'b1;
        rs1_used_s = 1'b1;
        op1_s      = inst_addr_i;
        op2_s      = FOUR_X;
        j1_s       = reg1_data_i;
        j2_s       = i_imm_s;
      end
      OPC_BRANCH: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
        op1_s      = reg1_data_i;
        op2_s      = reg2_data_i;
        j1_s       = inst_addr_i;
        j2_s       = b_imm_s;
        ill_s      = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_LOAD: begin
        rs1_used_s = 1'b1;
        rd_wr_s    = 1'b1;
        is_load_s  = 1'b1;
        op1_s      = reg1_data_i;
        op2_s      = i_imm_s;
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill_s = 1'b0;
          3'b011, 3'b110:                         ill_s = (XLEN == 32);
          default:                                ill_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
        op1_s      = reg1_data_i;
        op2_s      = s_imm_s;
        case (f3_s)
          3'b000, 3'b001, 3'b010: ill_s = 1'b0;
          3'b011:                 ill_s = (XLEN == 32);
          default:                ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        rs1_used_s = 1'b1;
        rd_wr_s    = 1'b1;
        op1_s      = reg1_data_i;
        op2_s      = i_imm_s;
        // On RV64 the shift amount takes one more bit out of the funct7 field.
        if (f3_s == 3'b001) begin
          ill_s = (XLEN == 64) ? (inst_i[31:26] != 6'b000000) : (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          ill_s = (XLEN == 64) ?
                  ((inst_i[31:26] != 6'b000000) && (inst_i[31:26] != 6'b010000)) :
                  ((f7_s != 7'b0000000) && (f7_s != 7'b0100000));
        end else begin
          ill_s = 1'b0;
        end
      end
      OPC_OP: begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b1;
        rd_wr_s    = 1'b1;
        op1_s      = reg1_data_i;
        op2_s      = reg2_data_i;
        case (f7_s)
          7'b0000000: ill_s = 1'b0;
          7'b0100000: ill_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
          7'b0000001: ill_s = (M_EXT == 0);
          default:    ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM32: begin
        if (XLEN == 32) begin
          ill_s = 1'b1;
        end else begin
          rs1_used_s = 1'b1;
          rd_wr_s    = 1'b1;
          op1_s      = reg1_data_i;
          op2_s      = i_imm_s;
          case (f3_s)
            3'b000:  ill_s = 1'b0;
            3'b001:  ill_s = (f7_s != 7'b0000000);
            3'b101:  ill_s = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
            default: ill_s = 1'b1;
          endcase
        end
      end
      OPC_OP32: begin
        if (XLEN == 32) begin
          ill_s = 1'b1;
        end else begin
          rs1_used_s = 1'b1;
          rs2_used_s = 1'b1;
          rd_wr_s    = 1'b1;
          op1_s      = reg1_data_i;
          op2_s      = reg2_data_i;
          case (f7_s)
            7'b0000000: ill_s = !((f3_s == 3'b000) || (f3_s == 3'b001) || (f3_s == 3'b101));
            7'b0100000: ill_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
            7'b0000001: ill_s = (M_EXT == 0) || (f3_s == 3'b001) || (f3_s == 3'b010) ||
                                (f3_s == 3'b011);
            default:    ill_s = 1'b1;
          endcase
        end
      end
      OPC_FENCE: begin
        ill_s = 1'b0;
      end
      OPC_SYSTEM: begin
        if (f3_s == 3'b000) begin
          ill_s = 1'b0;
        end else if ((ZICSR == 0) || (f3_s == 3'b100)) begin
          ill_s = 1'b1;
        end else begin
          csr_op_s   = 1'b1;
          rd_wr_s    = 1'b1;
          rs1_used_s = !f3_s[2];
          op1_s      = f3_s[2] ? uimm_s : reg1_data_i;
          // Set/clear with a zero mask only reads the CSR.
          csr_wr_s   = (f3_s[1:0] == 2'b01) || (rs1_s != 5'd0);
        end
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase
  end

  logic out_valid_r, is_load_r, capture_s, rd_hit_s;
  logic [4:0] reg_wr_addr_r;

  assign reg1_addr_o   = rs1_used_s ? rs1_s : 5'd0;
  assign reg2_addr_o   = rs2_used_s ? rs2_s : 5'd0;
  assign csr_rd_addr_o = csr_op_s ? inst_i[31:20] : 12'h000;

  assign rd_hit_s = (rs1_used_s && (rs1_s == reg_wr_addr_r)) ||
                    (rs2_used_s && (rs2_s == reg_wr_addr_r));
  assign load_use_stall_o = out_valid_r && is_load_r && (reg_wr_addr_r != 5'd0) &&
                            rd_hit_s && in_valid_i;
  assign in_ready_o = (!out_valid_r || out_ready_i) && !load_use_stall_o && !flush_i;
  assign capture_s  = in_valid_i && in_ready_o;

  logic [31:0]     inst_r;
  logic [XLEN-1:0] inst_addr_r, op1_r, op2_r, j1_r, j2_r, r1d_r, r2d_r, csrd_r;
  logic            reg_wr_en_r, csr_wr_en_r, illegal_r;
  logic [11:0]     csr_wr_addr_r;

  // Output register: flush kills, capture loads, drain empties, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      inst_r        <= 32'h0000_0000;
      inst_addr_r   <= ZERO_X;
      op1_r         <= ZERO_X;
      op2_r         <= ZERO_X;
      j1_r          <= ZERO_X;
      j2_r          <= ZERO_X;
      r1d_r         <= ZERO_X;
      r2d_r         <= ZERO_X;
      csrd_r        <= ZERO_X;
      reg_wr_en_r   <= 1'b0;
      reg_wr_addr_r <= 5'd0;
      csr_wr_en_r   <= 1'b0;
      csr_wr_addr_r <= 12'h000;
      illegal_r     <= 1'b0;
      is_load_r     <= 1'b0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r   <= 1'b1;
      inst_r        <= inst_i;
      inst_addr_r   <= inst_addr_i;
      op1_r         <= ill_s ? ZERO_X : op1_s;
      op2_r         <= ill_s ? ZERO_X : op2_s;
      j1_r          <= ill_s ? ZERO_X : j1_s;
      j2_r          <= ill_s ? ZERO_X : j2_s;
      r1d_r         <= ill_s ? ZERO_X : reg1_data_i;
      r2d_r         <= ill_s ? ZERO_X : reg2_data_i;
      csrd_r        <= (csr_op_s && !ill_s) ? csr_data_i : ZERO_X;
      reg_wr_en_r   <= rd_wr_s && !ill_s && (rd_s != 5'd0);
      reg_wr_addr_r <= (rd_wr_s && !ill_s) ? rd_s : 5'd0;
      csr_wr_en_r   <= csr_wr_s && !ill_s;
      csr_wr_addr_r <= (csr_op_s && !ill_s) ? inst_i[31:20] : 12'h000;
      illegal_r     <= ill_s;
      is_load_r     <= is_load_s && !ill_s;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid_o   = out_valid_r;
  assign inst_o        = inst_r;
  assign inst_addr_o   = inst_addr_r;
  assign op1_o         = op1_r;
  assign op2_o         = op2_r;
  assign op1_jump_o    = j1_r;
  assign op2_jump_o    = j2_r;
  assign reg1_data_o   = r1d_r;
  assign reg2_data_o   = r2d_r;
  assign csr_data_o    = csrd_r;
  assign reg_wr_en_o   = reg_wr_en_r;
  assign reg_wr_addr_o = reg_wr_addr_r;
  assign csr_wr_en_o   = csr_wr_en_r;
  assign csr_wr_addr_o = csr_wr_addr_r;
  assign illegal_o     = illegal_r;
  assign is_load_o     = is_load_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: RV32 instance checked through a scoreboard,
// plus an RV64 instance without the M extension for parameter-dependent decoding.
module tb_decode_stage_pipe;

  typedef struct {
    logic [31:0] inst, op1, op2, j1, j2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic        ill, ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] inst_i, inst_addr_i, reg1_data_i, reg2_data_i, csr_data_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o, reg_wr_addr_o;
  logic [11:0] csr_rd_addr_o, csr_wr_addr_o;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o, op2_jump_o;
  logic [31:0] reg1_data_o, reg2_data_o, csr_data_o;
  logic        reg_wr_en_o, csr_wr_en_o, illegal_o, is_load_o, load_use_stall_o;

  logic        v64, rdy64, ov64, wr_en64, csr_en64, ill64, ld64, stall64;
  logic [31:0] inst64, inst_o64;
  logic [63:0] pc64, r1_64, r2_64, csr64, pc_o64, op1_64, op2_64, j1_64, j2_64;
  logic [63:0] r1o64, r2o64, csro64;
  logic [4:0]  ra1_64, ra2_64, wa64;
  logic [11:0] csr_ra64, csr_wa64;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t exp_cur;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(32), .M_EXT(1), .ZICSR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .reg1_addr_o(reg1_addr_o),
    .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .csr_data_i(csr_data_i), .csr_rd_addr_o(csr_rd_addr_o), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o), .op1_jump_o(op1_jump_o),
    .op2_jump_o(op2_jump_o), .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
    .csr_data_o(csr_data_o), .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
    .csr_wr_en_o(csr_wr_en_o), .csr_wr_addr_o(csr_wr_addr_o), .illegal_o(illegal_o),
    .is_load_o(is_load_o), .load_use_stall_o(load_use_stall_o)
  );

  decode_stage_pipe #(.XLEN(64), .M_EXT(0), .ZICSR(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v64), .in_ready_o(rdy64),
    .inst_i(inst64), .inst_addr_i(pc64), .reg1_addr_o(ra1_64),
    .reg2_addr_o(ra2_64), .reg1_data_i(r1_64), .reg2_data_i(r2_64),
    .csr_data_i(csr64), .csr_rd_addr_o(csr_ra64), .flush_i(1'b0),
    .out_valid_o(ov64), .out_ready_i(1'b1), .inst_o(inst_o64),
    .inst_addr_o(pc_o64), .op1_o(op1_64), .op2_o(op2_64), .op1_jump_o(j1_64),
    .op2_jump_o(j2_64), .reg1_data_o(r1o64), .reg2_data_o(r2o64),
    .csr_data_o(csro64), .reg_wr_en_o(wr_en64), .reg_wr_addr_o(wa64),
    .csr_wr_en_o(csr_en64), .csr_wr_addr_o(csr_wa64), .illegal_o(ill64),
    .is_load_o(ld64), .load_use_stall_o(stall64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, op1, op2, j1, j2,
                              input logic wr_en, input logic [4:0] wr_addr,
                              input logic csr_en, input logic [11:0] csr_addr,
                              input logic ill, input logic ld);
    exp_t e;
    e.inst = inst; e.op1 = op1; e.op2 = op2; e.j1 = j1; e.j2 = j2;
    e.wr_en = wr_en; e.wr_addr = wr_addr; e.csr_en = csr_en; e.csr_addr = csr_addr;
    e.ill = ill; e.ld = ld;
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [31:0] inst);
    return mk(inst, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 12'h000, 1'b1, 1'b0);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [31:0] inst, pc, r1, r2, csr, input exp_t e);
    in_valid_i  = 1'b1;
    inst_i      = inst;
    inst_addr_i = pc;
    reg1_data_i = r1;
    reg2_data_i = r2;
    csr_data_i  = csr;
    exp_cur     = e;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    inst_i     = 32'h0000_0013;
  endtask

  // Scoreboard: push on accept, pop and compare on drain; flush and reset discard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL sb_unexpected: observed output %0h, expected none", inst_o);
        end else begin
          e = sb.pop_front();
          chk("sb_inst", inst_o, e.inst);
          chk("sb_op1", op1_o, e.op1);
          chk("sb_op2", op2_o, e.op2);
          chk("sb_j1", op1_jump_o, e.j1);
          chk("sb_j2", op2_jump_o, e.j2);
          chk("sb_wr_en", reg_wr_en_o, e.wr_en);
          chk("sb_wr_addr", reg_wr_addr_o, e.wr_addr);
          chk("sb_csr_en", csr_wr_en_o, e.csr_en);
          chk("sb_csr_addr", csr_wr_addr_o, e.csr_addr);
          chk("sb_illegal", illegal_o, e.ill);
          chk("sb_is_load", is_load_o, e.ld);
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(exp_cur);
    end
  end

  initial begin
    rst_n = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; idle();
    inst_addr_i = 32'h0; reg1_data_i = 32'h0; reg2_data_i = 32'h0; csr_data_i = 32'h0;
    v64 = 1'b0; inst64 = 32'h0000_0013; pc64 = 64'h0; r1_64 = 64'h0; r2_64 = 64'h0;
    csr64 = 64'h0;
    exp_cur = mk_ill(32'h0);
    repeat (3) cyc();
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_op1", op1_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_wr_en", reg_wr_en_o, 1'b0);
    chk("rst_csr_addr", csr_wr_addr_o, 12'h000);
    chk("rst_illegal", illegal_o, 1'b0);
    rst_n = 1'b1;
    #1 chk("rst_ready", in_ready_o, 1'b1);
    cyc();

    // ADDI x5,x1,-3 with one-cycle latency
    out_ready_i = 1'b1;
    set_in(32'hFFD08293, 32'h0, 32'd10, 32'h0, 32'h0,
           mk(32'hFFD08293, 32'd10, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 12'h000, 1'b0, 1'b0));
    #1 chk("addi_rs1_addr", reg1_addr_o, 5'd1);
    chk("addi_csr_rd_addr", csr_rd_addr_o, 12'h000);
    cyc(); idle();
    chk("addi_latency", out_valid_o, 1'b1);
    chk("addi_op2", op2_o, 32'hFFFFFFFD);
    cyc();

    // LW x6,0(x2) then dependent ADD x7,x6,x3: one bubble
    set_in(32'h00012303, 32'h10, 32'h40, 32'h0, 32'h0,
           mk(32'h00012303, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 12'h000, 1'b0, 1'b1));
    cyc();
    set_in(32'h003303B3, 32'h14, 32'h11, 32'h22, 32'h0,
           mk(32'h003303B3, 32'h11, 32'h22, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0, 12'h000, 1'b0, 1'b0));
    #1 chk("lu_stall", load_use_stall_o, 1'b1);
    chk("lu_ready", in_ready_o, 1'b0);
    cyc();
    #1 chk("lu_bubble", out_valid_o, 1'b0);
    chk("lu_stall_clear", load_use_stall_o, 1'b0);
    chk("lu_ready_back", in_ready_o, 1'b1);
    cyc(); idle();
    chk("lu_issued", inst_o, 32'h003303B3);
    cyc();

    // LW x6 then independent ADD x7,x4,x3: no stall
    set_in(32'h00012303, 32'h20, 32'h40, 32'h0, 32'h0,
           mk(32'h00012303, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 12'h000, 1'b0, 1'b1));
    cyc();
    set_in(32'h003203B3, 32'h24, 32'h33, 32'h44, 32'h0,
           mk(32'h003203B3, 32'h33, 32'h44, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0, 12'h000, 1'b0, 1'b0));
    #1 chk("nolu_stall", load_use_stall_o, 1'b0);
    chk("nolu_ready", in_ready_o, 1'b1);
    cyc(); idle(); cyc();

    // Backpressure then flush
    out_ready_i = 1'b0;
    set_in(32'h12345417, 32'h100, 32'h0, 32'h0, 32'h0,
           mk(32'h12345417, 32'h12345000, 32'h100, 32'h0, 32'h0, 1'b1, 5'd8, 1'b0, 12'h000, 1'b0, 1'b0));
    cyc();
    set_in(32'h00100493, 32'h104, 32'h0, 32'h0, 32'h0,
           mk(32'h00100493, 32'h0, 32'h1, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 12'h000, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready_o, 1'b0);
      chk("bp_valid", out_valid_o, 1'b1);
      chk("bp_op1", op1_o, 32'h12345000);
      chk("bp_op2", op2_o, 32'h100);
      chk("bp_inst", inst_o, 32'h12345417);
      cyc();
    end
    flush_i = 1'b1;
    #1 chk("flush_ready", in_ready_o, 1'b0);
    cyc();
    flush_i = 1'b0; idle();
    #1 chk("flush_valid", out_valid_o, 1'b0);
    cyc();
    chk("flush_not_accepted", out_valid_o, 1'b0);
    out_ready_i = 1'b1;

    // CSR ops, back to back
    set_in(32'h300020F3, 32'h30, 32'h0, 32'h0, 32'h1800,
           mk(32'h300020F3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0, 12'h300, 1'b0, 1'b0));
    #1 chk("csrrs_rd_addr", csr_rd_addr_o, 12'h300);
    cyc();
    chk("csrrs_data", csr_data_o, 32'h1800);
    set_in(32'h3053D073, 32'h34, 32'h0, 32'h0, 32'h55,
           mk(32'h3053D073, 32'h7, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 12'h305, 1'b0, 1'b0));
    #1 chk("csrrwi_ready", in_ready_o, 1'b1);
    cyc();

    // Branch, jump, MUL, ECALL and illegal encodings at full throughput
    set_in(32'h00208463, 32'h200, 32'h5, 32'h6, 32'h0,
           mk(32'h00208463, 32'h5, 32'h6, 32'h200, 32'h8, 1'b0, 5'd0, 1'b0, 12'h000, 1'b0, 1'b0));
    #1 chk("beq_rs2_addr", reg2_addr_o, 5'd2);
    cyc();
    set_in(32'hFFDFF0EF, 32'h300, 32'h0, 32'h0, 32'h0,
           mk(32'hFFDFF0EF, 32'h300, 32'h4, 32'h300, 32'hFFFFFFFC, 1'b1, 5'd1, 1'b0, 12'h000, 1'b0, 1'b0));
    cyc();
    set_in(32'h022081B3, 32'h304, 32'h3, 32'h4, 32'h0,
           mk(32'h022081B3, 32'h3, 32'h4, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 12'h000, 1'b0, 1'b0));
    cyc();
    set_in(32'h00000073, 32'h308, 32'h0, 32'h0, 32'h0,
           mk(32'h00000073, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 12'h000, 1'b0, 1'b0));
    cyc();
    set_in(32'h0000007F, 32'h30C, 32'h99, 32'h0, 32'h0, mk_ill(32'h0000007F));
    cyc();
    set_in(32'h40001033, 32'h310, 32'h1, 32'h2, 32'h0, mk_ill(32'h40001033));
    cyc();
    set_in(32'h0000B283, 32'h314, 32'h50, 32'h0, 32'h0, mk_ill(32'h0000B283));
    #1 chk("ld32_ready", in_ready_o, 1'b1);
    cyc(); idle(); cyc(); cyc();

    // Reset while holding an instruction drops it
    out_ready_i = 1'b0;
    set_in(32'hFFD08293, 32'h400, 32'd10, 32'h0, 32'h0,
           mk(32'hFFD08293, 32'd10, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 12'h000, 1'b0, 1'b0));
    cyc(); idle();
    chk("mid_held", out_valid_o, 1'b1);
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", out_valid_o, 1'b0);
    chk("mid_rst_op1", op1_o, 32'h0);
    chk("mid_rst_wr_en", reg_wr_en_o, 1'b0);
    cyc();
    rst_n = 1'b1; out_ready_i = 1'b1;
    cyc();

    // RV64 without M: LD legal with 64-bit sign extension, MUL illegal
    v64 = 1'b1; inst64 = 32'hFF80B283; r1_64 = 64'h1000;
    cyc();
    v64 = 1'b0;
    chk("ld64_valid", ov64, 1'b1);
    chk("ld64_op1", op1_64, 64'h1000);
    chk("ld64_op2", op2_64, 64'hFFFFFFFFFFFFFFF8);
    chk("ld64_illegal", ill64, 1'b0);
    chk("ld64_is_load", ld64, 1'b1);
    chk("ld64_wr_en", wr_en64, 1'b1);
    v64 = 1'b1; inst64 = 32'h022081B3; r1_64 = 64'h3; r2_64 = 64'h4;
    cyc();
    v64 = 1'b0;
    chk("mul64_illegal", ill64, 1'b1);
    chk("mul64_wr_en", wr_en64, 1'b0);
    chk("mul64_op1", op1_64, 64'h0);
    cyc(); cyc();

    chk("sb_drained", sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
